// File: rtl/mux8_arb_pkg.sv
// Shared constants, state type and round-robin pick helper for mux8_rr_arbiter.
package mux8_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_e;

  // First asserted requester at or after ptr, wrapping modulo N_REQ.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                               input logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    rr_pick = ptr;
    // Walk from the far end so the closest match to ptr is assigned last.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req_v[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux8x1.sv
// Plain 8:1 single-bit multiplexer used as the arbiter datapath.
module mux8x1
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] in,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  assign y = in[sel];

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Eight-way round-robin arbiter driving a shared 8:1 mux, one grant per packet.
// Optional per-grant transfer limit enabled by defining MUX8_ARB_MAXHOLD_EN.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  input  logic             last,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             y,
  output logic             y_valid
);

  if (HOLD_MAX < 1) begin : g_hold_max_check
    $error("mux8_rr_arbiter: HOLD_MAX must be at least 1");
  end

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             xfer;
  logic             hold_hit;
  logic             release_gnt;

  assign busy    = (state_q == GRANT);
  assign y_valid = busy & req[sel_q];
  assign xfer    = y_valid & out_ready;
  assign sel     = sel_q;
  assign gnt     = gnt_q;

`ifdef MUX8_ARB_MAXHOLD_EN
  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);

  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;

  // Reaching HOLD_MAX on this transfer ends the grant exactly like last.
  assign hold_hit = xfer && (hold_cnt_q == CntW'(HOLD_MAX - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == IDLE) begin
      hold_cnt_d = '0;
    end else if (xfer) begin
      hold_cnt_d = hold_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  // A dropped request releases even without a transfer.
  assign release_gnt = (xfer && (last || hold_hit)) || !req[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = rr_pick(req, ptr_q);
          gnt_d   = N_REQ'(1) << sel_d;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_gnt) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + SEL_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  mux8x1 u_mux (
    .in  (data_in),
    .sel (sel_q),
    .y   (y)
  );

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_mux8_rr_arbiter;

  localparam int HoldMax = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] data_in;
  logic       last;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       y;
  logic       y_valid;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  bit m_busy;
  int m_sel;
  int m_ptr;
  int m_cnt;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(
    .HOLD_MAX (HoldMax)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .last      (last),
    .out_ready (out_ready),
    .sel       (sel),
    .gnt       (gnt),
    .busy      (busy),
    .y         (y),
    .y_valid   (y_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_step();
    bit xfer;
    bit rel;
    if (rst) begin
      m_busy = 0;
      m_sel  = 0;
      m_ptr  = 0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        if (req[(m_ptr + k) % 8]) begin
          m_sel  = (m_ptr + k) % 8;
          m_busy = 1;
          m_cnt  = 0;
          break;
        end
      end
    end else begin
      xfer = req[m_sel] && out_ready;
      rel  = !req[m_sel] || (xfer && last);
`ifdef MUX8_ARB_MAXHOLD_EN
      if (xfer) m_cnt++;
      if (xfer && m_cnt == HoldMax) rel = 1;
`endif
      if (rel) begin
        m_busy = 0;
        m_ptr  = (m_sel + 1) % 8;
      end
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_gnt;
    exp_gnt = m_busy ? (8'h01 << m_sel) : 8'h00;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("sel", 32'(sel), 32'(m_sel));
    check("busy", 32'(busy), 32'(m_busy));
    check("y_valid", 32'(y_valid), 32'(m_busy && req[m_sel]));
    check("y", 32'(y), 32'(data_in[m_sel]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; last = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; data_in = 8'h00; last = 1'b0; out_ready = 1'b0;
    m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;

    // Idle after reset.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      check("idle_gnt", 32'(gnt), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
      check("idle_sel", 32'(sel), 32'h0);
    end

    // Two requesters: 2 first, then 5 after a bubble.
    do_reset();
    req = 8'h24; last = 1'b1; out_ready = 1'b1;
    tick();
    check("rr_first_gnt", 32'(gnt), 32'h04);
    check("rr_first_sel", 32'(sel), 32'd2);
    tick();
    check("rr_bubble_busy", 32'(busy), 32'h0);
    tick();
    check("rr_second_gnt", 32'(gnt), 32'h20);
    check("rr_second_sel", 32'(sel), 32'd5);

    // Pointer wraps from 7 to 0.
    do_reset();
    req = 8'h80; last = 1'b1; out_ready = 1'b1;
    tick();
    check("wrap_gnt7", 32'(gnt), 32'h80);
    tick();
    req = 8'h81;
    tick();
    check("wrap_gnt0", 32'(gnt), 32'h01);

    // last without out_ready holds the grant.
    do_reset();
    req = 8'h08; last = 1'b1; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_gnt", 32'(gnt), 32'h08);
    end
    out_ready = 1'b1;
    tick();
    check("stall_release", 32'(gnt), 32'h00);

    // Mux steering per requester.
    do_reset();
    data_in = 8'b1010_1010;
    for (int i = 0; i < 8; i++) begin
      req = 8'h01 << i; last = 1'b0; out_ready = 1'b1;
      tick();
      check("mux_yv", 32'(y_valid), 32'h1);
      check("mux_y", 32'(y), 32'(data_in[i]));
      last = 1'b1;
      tick();
      req = 8'h00; last = 1'b0;
      tick();
    end

`ifdef MUX8_ARB_MAXHOLD_EN
    // Hold limit and reset mid-grant.
    do_reset();
    req = 8'h02; last = 1'b0; out_ready = 1'b1;
    tick();
    for (int c = 0; c < HoldMax - 1; c++) tick();
    check("hold_still_busy", 32'(busy), 32'h1);
    tick();
    check("hold_release", 32'(busy), 32'h0);
    tick();
    check("hold_regrant", 32'(gnt), 32'h02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("hold_rst_gnt", 32'(gnt), 32'h00);
    check("hold_rst_busy", 32'(busy), 32'h0);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      data_in   = 8'($urandom);
      last      = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
MUX8_RR_ARBITER -- requirements
Module: mux8_rr_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, default 16, maximum accepted transfers per grant; used only when MUX8_ARB_MAXHOLD_EN is defined.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port: clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: req  input  8  per-requester request, req[i] for requester i.
REQ-006 Port: data_in  input  8  per-requester data bit, data_in[i] from requester i.
REQ-007 Port: last  input  1  from the granted requester; marks its final transfer.
REQ-008 Port: out_ready  input  1  sink accepts y this cycle.
REQ-009 Port: sel  output  3  registered select, drives the shared 8:1 mux.
REQ-010 Port: gnt  output  8  registered one-hot grant, gnt[sel] when busy, else 0.
REQ-011 Port: busy  output  1  high in state GRANT.
REQ-012 Port: y  output  1  data_in[sel] through the 8:1 mux.
REQ-013 Port: y_valid  output  1  busy && req[sel].

Function
REQ-014 FSM states: IDLE, GRANT; exactly one 3-bit round-robin pointer ptr.
REQ-015 IDLE: if req != 0, select first i with req[i]=1 searching ptr, ptr+1, ... mod 8; register sel=i, gnt=1<<i; next state GRANT.
REQ-016 IDLE with req == 0: stay IDLE, sel, gnt, ptr unchanged.
REQ-017 Grant latency: gnt/busy assert exactly one cycle after req is sampled in IDLE.
REQ-018 Transfer: occurs on any GRANT cycle with y_valid=1 and out_ready=1.
REQ-019 GRANT release: on a transfer with last=1, or on any cycle with req[sel]=0; next state IDLE, gnt cleared, ptr = sel+1 mod 8 (7 wraps to 0).
REQ-020 last=1 with out_ready=0: no transfer, no release; grant held.
REQ-021 One idle bubble cycle SHALL separate consecutive grants; no direct GRANT-to-GRANT transition.
REQ-022 Requests from other requesters during GRANT SHALL be ignored until IDLE.
REQ-023 sel SHALL hold its value in IDLE; y remains data_in[sel] but y_valid=0.

Reset
REQ-024 On rst=1 at posedge clk: state=IDLE, sel=0, gnt=0, ptr=0, busy=0, y_valid=0, hold counter=0.
REQ-025 Reset mid-GRANT SHALL abort the grant in the same edge; no release side-effect on ptr (ptr=0).

Configuration
REQ-026 Macro MUX8_ARB_MAXHOLD_EN defined: counter counts transfers in GRANT; the HOLD_MAX-th transfer forces release as if last=1; counter clears on entering GRANT.
REQ-027 Macro undefined: no counter; grant held until last or req drop, unbounded.

Structure
REQ-028 Package mux8_arb_pkg SHALL hold N_REQ=8, SEL_W=3, and the state enum (IDLE, GRANT).
REQ-029 Datapath SHALL instantiate the existing mux8x1 sub-module (in=data_in, sel=sel, y=y); no other sub-modules.

Verification
REQ-030 Reset then req=8'h00 for 5 cycles -> gnt=0, busy=0, sel=0, y_valid=0 throughout.
REQ-031 req=8'h24 from reset -> cycle+1 gnt=8'h04, sel=2; after last transfer next grant gnt=8'h20, sel=5.
REQ-032 Grant on requester 7, release -> ptr=0; with req=8'h81 next gnt=8'h01.
REQ-033 Granted requester 3, last=1, out_ready=0 for 3 cycles -> gnt held; out_ready=1 -> release next edge.
REQ-034 data_in=8'b10101010, grant each i in turn -> y=data_in[i] while y_valid=1.
REQ-035 MUX8_ARB_MAXHOLD_EN, HOLD_MAX=16, req[1] held, last=0, out_ready=1 -> release after 16th transfer; rst mid-grant -> IDLE, gnt=0 next edge.
